fetch_controller: RTL
=====================

# fetch_controller

Sequences instruction fetch for the 32-bit core: owns the fetch PC, issues one request at a time on the instruction-memory request/grant/response handshake, and presents each fetched instruction with its PC to decode under a valid/ready handshake. It accepts redirects (taken branch, JAL, JALR) from execute and flushes in-flight or held wrong-path fetches. It sits at the head of the fetch stage, between instruction memory and the IF/ID boundary.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- redirect_valid  in  1  execute resolved a taken control transfer this cycle
- redirect_target  in  32  absolute target address, already resolved by execute
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address, word-aligned
- imem_gnt  in  1  request accepted this cycle
- imem_rvalid  in  1  response data valid this cycle
- imem_rdata  in  32  instruction word
- if_valid  out  1  instruction available to decode
- if_pc  out  32  PC of presented instruction
- if_instr  out  32  presented instruction
- if_ready  in  1  decode accepts this cycle
- fetch_misaligned  out  1  one-cycle pulse: last redirect target had bits [1:0] != 0

## Operation
- States: IDLE, REQ, WAIT, HOLD, DRAIN. At most one memory request outstanding.
- Reset: state IDLE, pc = RESET_PC. if_pc = 0, if_instr = 0, fetch_misaligned = 0. if_valid = 0 and imem_req = 0, because both are decoded from state.
- IDLE: no request. Next cycle -> REQ.
- REQ: imem_req = 1, imem_addr = pc.
  - gnt and no redirect -> WAIT.
  - gnt with redirect -> DRAIN, pc <= target.
  - Redirect without gnt -> stay REQ, pc <= target. The address may change only in this case; otherwise it holds until gnt.
- WAIT: request outstanding.
  - rvalid and no redirect: if_instr <= rdata, if_pc <= pc, pc <= pc + 4 -> HOLD.
  - rvalid with redirect: response dropped, pc <= target -> REQ.
  - Redirect without rvalid: pc <= target -> DRAIN.
- HOLD: if_valid = ~redirect_valid. Redirect masks the transfer combinationally.
  - if_ready with no redirect -> REQ.
  - Redirect: pc <= target -> REQ; the held instruction is flushed.
  - Otherwise hold; if_pc and if_instr stay stable.
- DRAIN: awaits the stale response, which is discarded.
  - rvalid -> REQ.
  - Redirect without rvalid: pc <= target, stay DRAIN. The newest target wins.
  - Redirect with rvalid: pc <= target -> REQ.
- Redirect address rule: pc <= {redirect_target[31:2], 2'b00}. fetch_misaligned <= redirect_valid & |redirect_target[1:0] (registered pulse).
- Arithmetic: pc + 4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
- rst has priority over every event in every state, including mid-request. Any response arriving after reset is ignored; the memory side is reset on the same rst.
- rvalid in IDLE, REQ or HOLD is a protocol error and is ignored.

## Timing
- Reset deassert edge -> 1 cycle IDLE -> imem_req high on the 2nd cycle.
- Zero-wait memory (gnt in REQ cycle, rvalid the following cycle): if_valid rises the cycle after rvalid.
- Peak throughput: 1 instruction per 3 cycles (REQ, WAIT, HOLD), with no bubbles beyond those.
- Redirect latency: the target appears on imem_addr 1 cycle after the redirect when in REQ or HOLD. From WAIT or DRAIN, it appears 1 cycle after the stale rvalid.
- if_valid has one combinational input, redirect_valid. All other outputs are registered or decoded from state.

## Structure
- Package fetch_pkg holds:
  - fetch_state_e enum {IDLE, REQ, WAIT, HOLD, DRAIN}
  - INSTR_BYTES = 4
  - PC_ALIGN_MASK = 32'hFFFF_FFFC
- One sub-module, fetch_pc_next. It is combinational next-PC selection: hold, pc + 4, or aligned redirect target. It takes select inputs from the FSM; the pc register stays in fetch_controller.

## Test plan
- Reset, zero-wait memory, if_ready = 1, RESET_PC = 0: check the following.
  - imem_addr sequence is 0, 4, 8, 12.
  - if_pc matches each address, one instruction per 3 cycles.
  - No request in the IDLE cycle.
- Backpressure: if_ready = 0 for 5 cycles in HOLD with if_instr = 32'h0000_0013. Required:
  - if_valid, if_pc and if_instr stay stable.
  - No imem_req is issued.
  - The instruction is accepted on the cycle if_ready rises.
- Redirect in WAIT: target 32'h100 while the response for 32'h8 is outstanding with rvalid 3 cycles later. Required:
  - The response is discarded and if_valid never rises for it.
  - The next imem_addr is 32'h100.
  - A second redirect during DRAIN to 32'h200 makes 32'h200 the next fetch.
- Redirect in HOLD with if_ready = 1 the same cycle: if_valid = 0 in that cycle and the held instruction is never transferred. Next fetch is the target.
- Misaligned redirect to 32'h0000_0106: imem_addr = 32'h104 and fetch_misaligned pulses for exactly 1 cycle. Separately, pc 32'hFFFF_FFFC followed by a sequential fetch gives imem_addr 0.
- rst asserted in WAIT with an outstanding request. Required:
  - The next cycle is IDLE with pc = RESET_PC.
  - if_valid = 0 and fetch_misaligned = 0.
  - A late rvalid is ignored.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD,
    DRAIN
  } fetch_state_e;

  localparam int unsigned INSTR_BYTES   = 4;
  localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/fetch_pc_next.sv
// Combinational next-PC selection: hold, sequential increment or aligned redirect target.
module fetch_pc_next
  import fetch_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] redirect_target,
  input  logic        sel_inc,
  input  logic        sel_redirect,
  output logic [31:0] pc_next
);

  always_comb begin
    pc_next = pc;
    if (sel_redirect) begin
      pc_next = redirect_target & PC_ALIGN_MASK;
    end else if (sel_inc) begin
      pc_next = pc + INSTR_BYTES;
    end
  end

endmodule

// File: rtl/fetch_controller.sv
// Fetch-stage sequencer: owns the PC, keeps one imem request outstanding at a time and
// hands fetched instructions to decode, flushing wrong-path fetches on redirect.
module fetch_controller
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  input  logic        if_ready,
  output logic        fetch_misaligned
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_next;
  logic [31:0]  if_pc_q, if_instr_q;
  logic         misaligned_q;
  logic         sel_inc, sel_redirect, capture;

  fetch_pc_next u_pc_next (
    .pc              (pc_q),
    .redirect_target (redirect_target),
    .sel_inc         (sel_inc),
    .sel_redirect    (sel_redirect),
    .pc_next         (pc_next)
  );

  always_comb begin
    state_d      = state_q;
    sel_inc      = 1'b0;
    sel_redirect = 1'b0;
    capture      = 1'b0;
    imem_req     = 1'b0;
    if_valid     = 1'b0;
    unique case (state_q)
      IDLE: begin
        sel_redirect = redirect_valid;
        state_d      = REQ;
      end
      REQ: begin
        imem_req     = 1'b1;
        sel_redirect = redirect_valid;
        if (imem_gnt) state_d = redirect_valid ? DRAIN : WAIT;
      end
      WAIT: begin
        sel_redirect = redirect_valid;
        if (imem_rvalid) begin
          // A response racing a redirect belongs to the wrong path and is dropped.
          capture = ~redirect_valid;
          sel_inc = ~redirect_valid;
          state_d = redirect_valid ? REQ : HOLD;
        end else if (redirect_valid) begin
          state_d = DRAIN;
        end
      end
      HOLD: begin
        // Redirect masks the handoff in the same cycle so decode never sees a flushed instr.
        if_valid     = ~redirect_valid;
        sel_redirect = redirect_valid;
        if (redirect_valid || if_ready) state_d = REQ;
      end
      DRAIN: begin
        sel_redirect = redirect_valid;
        if (imem_rvalid) state_d = REQ;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      if_pc_q      <= 32'h0;
      if_instr_q   <= 32'h0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_next;
      misaligned_q <= redirect_valid & (|redirect_target[1:0]);
      if (capture) begin
        if_pc_q    <= pc_q;
        if_instr_q <= imem_rdata;
      end
    end
  end

  assign imem_addr        = pc_q;
  assign if_pc            = if_pc_q;
  assign if_instr         = if_instr_q;
  assign fetch_misaligned = misaligned_q;

endmodule
